rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter that sits directly upstream of the 4:1 data multiplexer and drives its 2-bit `control` input. Four sources request the shared path; the block grants one at a time and holds the mux select stable for the whole ownership. Ownership ends on release, on a dropped request, or on a timeout.

## Interface
Parameters:
- `TIMEOUT`, default 8: maximum consecutive cycles one source may own the mux. Legal range 2..255. The counter is 8 bits wide.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-source request. Bits 0..3 map to mux inputs A, B, C, D (select 00, 01, 10, 11).
- `done`  in  1  current owner releases the mux. Ignored when nothing is granted.
- `sel`  out  2  mux control. It is the binary index of the current or most recent owner.
- `grant`  out  4  one-hot grant, or 0000 when no source is granted.
- `busy`  out  1  high while any grant is asserted.
- `timeout`  out  1  one-cycle pulse indicating that the previous ownership was force-released.

## Operation
- Internal state: FSM {IDLE, OWN}; 2-bit last-owner pointer `ptr`; 8-bit ownership counter `cnt`.
- Reset values, applied immediately on `reset_n`=0 with no clock required:
  - state=IDLE, `grant`=0000, `busy`=0, `timeout`=0
  - `sel`=00, `ptr`=3, `cnt`=0
- IDLE:
  - `grant`=0000 and `busy`=0.
  - `sel` holds its previous value so the mux output does not glitch.
  - If `req`≠0, choose the first requesting source in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - At the next edge: state←OWN, `grant`←one-hot(choice), `sel`←choice, `ptr`←choice, `cnt`←0.
  - If `req`=0, remain in IDLE.
- OWN:
  - `grant` and `sel` are held constant; `cnt` increments each cycle.
  - Release conditions, sampled at the edge:
    - (a) `done`=1
    - (b) `req[sel]`=0
    - (c) `cnt`==TIMEOUT-1
  - On release: state←IDLE, `grant`←0000.
  - `timeout`←1 only if (c) holds and neither (a) nor (b) holds. Otherwise `timeout`←0.
- There is always exactly one IDLE cycle between consecutive ownerships, even if the same source is re-granted. This gap is the bus turnaround.
- `timeout` is registered and is high only during the IDLE cycle that follows a forced release.
- `busy` equals |`grant` and is driven from registered state.
- `req` bits of non-owners are ignored during OWN. They are not latched; only the `req` value present in IDLE matters.

## Timing
- Grant latency: `req` sampled at edge n while IDLE → `grant`/`sel`/`busy` valid after edge n (one cycle).
- Release latency: `done` sampled at edge k → `grant`=0000 after edge k. The earliest next grant is after edge k+1.
- With `done`=0 and `req` held, an ownership lasts exactly TIMEOUT cycles.
- Maximum wait for a continuously requesting source: 3×(TIMEOUT+1) cycles.
- Simultaneous events:
  - `done` and timeout in the same cycle: treated as a normal release, `timeout`=0.
  - `req` drop and `done` in the same cycle: a single release.
  - `ptr` wrap: ptr=3 → next candidate is 0.
- Reset asserted mid-OWN: outputs go to reset values asynchronously. The first rising edge after `reset_n` deasserts may issue a grant.
- All outputs are registered. There is no combinational path from `req` or `done` to any output.

## Test plan
- Reset: `reset_n`=0 with `req`=1111 → `grant`=0000, `sel`=00, `busy`=0, `timeout`=0. After release and the first edge → `grant`=0001, `sel`=00.
- Rotation: `req`=1111 held, `done`=1 → owners 0001, 0010, 0100, 1000, 0001. `sel` follows 00, 01, 10, 11, 00. Each grant lasts 1 cycle, and each is followed by a 1-cycle IDLE with `grant`=0000.
- Skip/priority: after source 1 owns and releases, drive `req`=1001 → `grant`=1000, `sel`=11 (search order 2, 3, 0, 1).
- Timeout: TIMEOUT=8, `req`=0100 held, `done`=0 → `grant`=0100 for exactly 8 cycles. Then 1 IDLE cycle with `timeout`=1, `grant`=0000, `sel` still 10. Then `grant`=0100 again.
- Coincident release: `done`=1 in the 8th OWN cycle → `timeout` stays 0. Separately, dropping `req[owner]` mid-OWN → `grant`=0000 next cycle, `timeout`=0.
- Async reset mid-grant: assert `reset_n`=0 between edges while `grant`=1000 → `grant`=0000 and `sel`=00 before the next edge. Release with `req`=0010 → `grant`=0010, `sel`=01 on the first edge.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving the 4:1 mux control
//
// Four sources compete for one shared mux path. Only one source is granted at a
// time, and the mux select is held for the whole ownership.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [3:0] per-source request (bit i -> mux input i)
//   done     in   owner releases the mux
//   sel      out  [1:0] index of the current or most recent owner
//   grant    out  [3:0] one-hot grant, 0 when idle
//   busy     out  high while a grant is asserted
//   timeout  out  one-cycle pulse after a forced release
module rr_mux_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, OWN} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    logic [1:0] pick;
    logic       found;
    logic [1:0] cand;

    // Search starts just after the last owner, so the last owner has lowest
    // priority and rotation is fair.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        cand  = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    grant_d = 4'b0001 << pick;
                    sel_d   = pick;
                    ptr_d   = pick;
                    cnt_d   = 8'd0;
                end
            end
            OWN: begin
                cnt_d = cnt_q + 8'd1;
                if (done || !req[sel_q] || (cnt_q == CNT_LAST)) begin
                    state_d   = IDLE;
                    grant_d   = 4'b0000;
                    // Forced release is flagged only when nothing else ended it.
                    timeout_d = (cnt_q == CNT_LAST) && !done && req[sel_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'b00;
            ptr_q     <= 2'd3;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign busy    = |grant_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
    } exp_t;

    exp_t sb[$];

    // Reference model: who owns, for how long, and who owned last.
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_len;
    int m_to;

    rr_mux_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .done(done),
        .sel(sel), .grant(grant), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_sel   = 0;
        m_len   = 0;
        m_to    = 0;
    endtask

    task automatic model_next(input logic [3:0] r, input logic d);
        if (m_owner < 0) begin
            m_to = 0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_sel   = c;
                    m_ptr   = c;
                    m_len   = 1;
                end
            end
        end else begin
            logic rb;
            rb = r[m_owner];
            if (d || !rb || m_len == TO) begin
                m_to    = (m_len == TO && !d && rb) ? 1 : 0;
                m_owner = -1;
            end else begin
                m_len++;
                m_to = 0;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        exp_t e;
        req  = r;
        done = d;
        model_next(r, d);
        e.g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.s = 2'(m_sel);
        e.b = (m_owner >= 0);
        e.t = 1'(m_to);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compares each cycle's DUT outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_grant", int'(grant), int'(e.g));
            chk("sb_sel", int'(sel), int'(e.s));
            chk("sb_busy", int'(busy), int'(e.b));
            chk("sb_timeout", int'(timeout), int'(e.t));
        end
    end

    logic [3:0] rot [8];
    logic [3:0] rq;

    initial begin
        model_reset();
        rot[0] = 4'b0000; rot[1] = 4'b0010; rot[2] = 4'b0000; rot[3] = 4'b0100;
        rot[4] = 4'b0000; rot[5] = 4'b1000; rot[6] = 4'b0000; rot[7] = 4'b0001;

        // Reset held with all sources requesting.
        req = 4'b1111;
        #22;
        chk("rst_grant", int'(grant), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        step(4'b1111, 1'b0);
        chk("first_grant", int'(grant), 1);
        chk("first_sel", int'(sel), 0);

        // Rotation with immediate release.
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b1);
            chk("rot_grant", int'(grant), int'(rot[i]));
        end

        // Skip: source 1 owns, then search order 2,3,0,1 picks source 3.
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b0);
        chk("own1_grant", int'(grant), 2);
        step(4'b0010, 1'b1);
        step(4'b1001, 1'b0);
        chk("skip_grant", int'(grant), 8);
        chk("skip_sel", int'(sel), 3);
        step(4'b0000, 1'b0);

        // Forced release after exactly TO cycles.
        for (int i = 0; i < TO; i++) begin
            step(4'b0100, 1'b0);
            chk("to_hold_grant", int'(grant), 4);
        end
        step(4'b0100, 1'b0);
        chk("to_gap_grant", int'(grant), 0);
        chk("to_gap_timeout", int'(timeout), 1);
        chk("to_gap_sel", int'(sel), 2);
        step(4'b0100, 1'b0);
        chk("to_regrant", int'(grant), 4);
        chk("to_regrant_timeout", int'(timeout), 0);

        // done coincides with the last allowed cycle.
        for (int i = 0; i < TO - 1; i++) step(4'b0100, 1'b0);
        chk("co_still_owned", int'(grant), 4);
        step(4'b0100, 1'b1);
        chk("co_grant", int'(grant), 0);
        chk("co_timeout", int'(timeout), 0);

        // Request drop mid-ownership.
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        chk("drop_grant", int'(grant), 0);
        chk("drop_timeout", int'(timeout), 0);

        // Asynchronous reset while source 3 owns.
        step(4'b1000, 1'b0);
        chk("pre_rst_grant", int'(grant), 8);
        reset_n = 1'b0;
        #1;
        chk("arst_grant", int'(grant), 0);
        chk("arst_sel", int'(sel), 0);
        chk("arst_busy", int'(busy), 0);
        model_reset();
        #1;
        reset_n = 1'b1;
        step(4'b0010, 1'b0);
        chk("post_rst_grant", int'(grant), 2);
        chk("post_rst_sel", int'(sel), 1);

        // Randomized traffic against the model.
        rq = 4'b0010;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            step(rq, ($urandom_range(0, 4) == 0));
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
